// File: rtl/ex_pipe_sequencer_pkg.sv
// ex_pipe_sequencer_pkg: sequencer state encoding and default multi-cycle latency
package ex_pipe_sequencer_pkg;
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_WAIT = 2'd1,
        HALT    = 2'd2
    } state_t;
    localparam int MULTI_CYCLE_LATENCY = 4;
endpackage

// File: rtl/ex_pipe_sequencer_pipe_flush_pulse.sv
// pipe_flush_pulse: registered flush pulse (fire -> pulse next cycle), async active-low Reset clears it
module pipe_flush_pulse (
    input  logic Clock,
    input  logic Reset,
    input  logic fire,
    output logic pulse
);
    always_ff @(posedge Clock or negedge Reset)
        if (!Reset) pulse <= 1'b0;
        else pulse <= fire;
endmodule

// File: rtl/ex_pipe_sequencer.sv
// ex_pipe_sequencer: Tick-qualified stall/flush sequencer driving pipeline register enables, flush pulses and stall statistics
module ex_pipe_sequencer
    import ex_pipe_sequencer_pkg::*;
#(
    parameter int MultiCycleLatency = MULTI_CYCLE_LATENCY,
    parameter int CntWidth = 6,
    parameter int StatWidth = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Tick,
    input  logic                 load_use_hazard,
    input  logic                 jal_ex,
    input  logic                 branch_taken_ex,
    input  logic                 mc_start,
    input  logic                 halt_req,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 id_ex_en,
    output logic                 ex_mem_en,
    output logic                 mem_wb_en,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_flush,
    output logic                 mc_busy,
    output logic                 halted,
    output logic [StatWidth-1:0] stall_count
);
    state_t state, state_nx;
    logic [CntWidth-1:0] cnt, cnt_nx;
    logic [4:0] en;
    logic fl_if_id, fl_id_ex, fl_ex_mem;
    always_comb begin
        state_nx = state;
        cnt_nx = cnt;
        en = 5'b11111;
        fl_if_id = 1'b0;
        fl_id_ex = 1'b0;
        fl_ex_mem = 1'b0;
        case (state)
            RUN:
                if (halt_req) begin
                    en = 5'b00000;
                    state_nx = HALT;
                end else if (jal_ex || branch_taken_ex) begin
                    fl_if_id = 1'b1;
                    fl_id_ex = 1'b1;
                end else if (mc_start) begin
                    en = 5'b00001;
                    fl_ex_mem = 1'b1;
                    cnt_nx = CntWidth'(MultiCycleLatency - 1);
                    state_nx = MC_WAIT;
                end else if (load_use_hazard) begin
                    en = 5'b00111;
                    fl_id_ex = 1'b1;
                end
            MC_WAIT:
                if (cnt != '0) begin
                    en = 5'b00001;
                    cnt_nx = cnt - 1'b1;
                end else begin
                    state_nx = RUN;
                end
            HALT: begin
                en = 5'b00000;
                state_nx = halt_req ? HALT : RUN;
            end
            default: state_nx = RUN;
        endcase
    end
    assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = en;
    assign mc_busy = state == MC_WAIT;
    assign halted = state == HALT;
    always_ff @(posedge Clock or negedge Reset)
        if (!Reset) begin
            state <= RUN;
            cnt <= '0;
            stall_count <= '0;
        end else if (Tick) begin
            state <= state_nx;
            cnt <= cnt_nx;
            if (!(&en) && !(&stall_count)) stall_count <= stall_count + 1'b1;
        end
    pipe_flush_pulse u_if_id_flush (
        .Clock(Clock),
        .Reset(Reset),
        .fire (Tick & fl_if_id),
        .pulse(if_id_flush)
    );
    pipe_flush_pulse u_id_ex_flush (
        .Clock(Clock),
        .Reset(Reset),
        .fire (Tick & fl_id_ex),
        .pulse(id_ex_flush)
    );
    pipe_flush_pulse u_ex_mem_flush (
        .Clock(Clock),
        .Reset(Reset),
        .fire (Tick & fl_ex_mem),
        .pulse(ex_mem_flush)
    );
endmodule

// File: tb/tb_ex_pipe_sequencer.sv
// tb_ex_pipe_sequencer: scoreboard bench for ex_pipe_sequencer against a behavioural model
module tb_ex_pipe_sequencer;
    localparam int MCL = 4;
    logic Clock, Reset, Tick;
    logic load_use_hazard, jal_ex, branch_taken_ex, mc_start, halt_req;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mc_busy, halted;
    logic [15:0] stall_count;
    typedef struct packed {
        logic [2:0]  fl;
        logic        busy;
        logic        halt;
        logic [15:0] stall;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int m_state, m_cnt, m_stall;
    ex_pipe_sequencer #(.MultiCycleLatency(MCL), .CntWidth(6), .StatWidth(16)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Tick(Tick),
        .load_use_hazard(load_use_hazard),
        .jal_ex(jal_ex),
        .branch_taken_ex(branch_taken_ex),
        .mc_start(mc_start),
        .halt_req(halt_req),
        .pc_en(pc_en),
        .if_id_en(if_id_en),
        .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush),
        .mc_busy(mc_busy),
        .halted(halted),
        .stall_count(stall_count)
    );
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;
    always @(posedge Clock)
        assert (!(mc_start && (jal_ex || branch_taken_ex)));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic model_reset();
        m_state = 0;
        m_cnt = 0;
        m_stall = 0;
    endtask
    task automatic step(input logic t, input logic h, input logic j, input logic b,
                        input logic mc, input logic lu, input bit do_chk);
        logic [4:0] en;
        logic [2:0] fl;
        int ns, nc;
        exp_t e, got;
        Tick = t; halt_req = h; jal_ex = j; branch_taken_ex = b; mc_start = mc; load_use_hazard = lu;
        en = 5'b11111; fl = 3'b000; ns = m_state; nc = m_cnt;
        if (m_state == 0) begin
            if (h) begin en = 5'b00000; ns = 2; end
            else if (j || b) fl = 3'b110;
            else if (mc) begin en = 5'b00001; fl = 3'b001; ns = 1; nc = MCL - 1; end
            else if (lu) begin en = 5'b00111; fl = 3'b010; end
        end else if (m_state == 1) begin
            if (m_cnt != 0) begin en = 5'b00001; nc = m_cnt - 1; end
            else ns = 0;
        end else begin
            en = 5'b00000;
            if (!h) ns = 0;
        end
        if (t) begin
            if (en != 5'b11111 && m_stall != 16'hFFFF) m_stall++;
            m_state = ns;
            m_cnt = nc;
        end
        #1;
        if (do_chk) begin
            check("enables", {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, {27'd0, en});
            e.fl = t ? fl : 3'b000;
            e.busy = m_state == 1;
            e.halt = m_state == 2;
            e.stall = m_stall[15:0];
            sb.push_back(e);
        end
        @(posedge Clock);
        #1;
        if (do_chk) begin
            e = sb.pop_front();
            got = {if_id_flush, id_ex_flush, ex_mem_flush, mc_busy, halted, stall_count};
            check("flush", {29'd0, got.fl}, {29'd0, e.fl});
            check("state", {30'd0, got.busy, got.halt}, {30'd0, e.busy, e.halt});
            check("stall_count", {16'd0, got.stall}, {16'd0, e.stall});
        end
    endtask
    task automatic idle(input int n, input logic t);
        for (int i = 0; i < n; i++) step(t, 0, 0, 0, 0, 0, 1);
    endtask
    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"}, {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, 32'h1F);
        check({tag, "_flush"}, {29'd0, if_id_flush, id_ex_flush, ex_mem_flush}, 32'd0);
        check({tag, "_busy_halt"}, {30'd0, mc_busy, halted}, 32'd0);
        check({tag, "_stall"}, {16'd0, stall_count}, 32'd0);
    endtask
    initial begin
        Reset = 1'b0;
        Tick = 0; halt_req = 0; jal_ex = 0; branch_taken_ex = 0; mc_start = 0; load_use_hazard = 0;
        model_reset();
        repeat (3) @(posedge Clock);
        #1;
        check_reset_outputs("reset");
        Reset = 1'b1;
        idle(3, 1);
        step(1, 0, 1, 0, 0, 0, 1);
        idle(2, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 1, 1);
        idle(2, 0);
        check("lu_stall", {16'd0, stall_count}, 32'd1);
        step(1, 0, 0, 0, 1, 0, 1);
        idle(5, 1);
        check("mc_stall", {16'd0, stall_count}, 32'd5);
        step(1, 0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(2, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        idle(3, 1);
        step(1, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0, 1);
        check("halted", {31'd0, halted}, 32'd1);
        step(0, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        idle(2, 1);
        step(1, 0, 0, 1, 0, 1, 1);
        step(1, 0, 1, 0, 0, 1, 1);
        step(1, 1, 1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        idle(2, 1);
        step(1, 0, 0, 0, 1, 0, 1);
        Tick = 0; mc_start = 0;
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("async_reset");
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        idle(2, 1);
        for (int i = 0; i < 70000; i++) step(1, 0, 0, 0, 0, 1, 0);
        check("saturate", {16'd0, stall_count}, 32'hFFFF);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1, 1);
        idle(2, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
